servo_scan_ctrl: RTL and testbench

- Sequencer that drives the control inputs (holder, tune, lock) of the rover's servo PWM block.
- Runs one sweep: steps the servo from MIN_ANGLE toward MAX_ANGLE, dwells at each position and samples an obstacle sensor.
- Stops and holds on the first hit, or re-centres the servo when the sweep is exhausted.
- Sits between the rover's top-level command logic and the servo PWM block; angles use the same 17-bit count units as the PWM block.

---
 rtl/servo_scan_ctrl_if.sv | 24 ++
 rtl/servo_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_servo_scan_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/servo_scan_ctrl_if.sv
// Command/status bundle between the rover command logic (master) and the
// servo scan sequencer (slave), including the PWM-side control outputs.
interface servo_scan_ctrl_if;
    logic        start;
    logic        abort;
    logic        obstacle;
    logic        holder;
    logic        tune;
    logic [16:0] lock;
    logic        busy;
    logic        done;
    logic        found;
    logic [16:0] found_angle;

    modport master (
        output start, abort, obstacle,
        input  holder, tune, lock, busy, done, found, found_angle
    );

    modport slave (
        input  start, abort, obstacle,
        output holder, tune, lock, busy, done, found, found_angle
    );
endinterface

// File: rtl/servo_scan_ctrl.sv
// Single-sweep obstacle scan: park at MIN_ANGLE, step and dwell at each
// position, hold on the first hit or re-centre once the sweep runs out.
module servo_scan_ctrl #(
    parameter logic [16:0] MIN_ANGLE = 17'd23000,
    parameter logic [16:0] MAX_ANGLE = 17'd127000,
    parameter logic [16:0] STEP      = 17'd8667,
    parameter logic [26:0] DWELL     = 27'd30000000,
    parameter logic [26:0] TRAVEL    = 27'd60000000
) (
    input  logic              clk3,
    input  logic              reset,
    servo_scan_ctrl_if.slave  bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PARK   = 3'd1;
    localparam logic [2:0] S_DWELL  = 3'd2;
    localparam logic [2:0] S_LOCKED = 3'd3;
    localparam logic [2:0] S_RETURN = 3'd4;

    logic [2:0]  state_reg, state_next;
    logic [26:0] cnt_reg, cnt_next;
    logic [16:0] lock_reg, lock_next;
    logic [16:0] angle_reg, angle_next;
    logic        holder_reg;
    logic        tune_reg, tune_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        found_reg, found_next;
    logic        exh_reg, exh_next;
    logic [17:0] sum;

    // One bit wider than lock so the bound check cannot wrap.
    assign sum = {1'b0, lock_reg} + {1'b0, STEP};

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 27'd1;
        lock_next  = lock_reg;
        angle_next = angle_reg;
        tune_next  = tune_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        found_next = found_reg;
        exh_next   = exh_reg;
        case (state_reg)
            S_IDLE: begin
                cnt_next = '0;
                if (!bus.abort && bus.start) begin
                    state_next = S_PARK;
                    found_next = 1'b0;
                    angle_next = '0;
                    lock_next  = MIN_ANGLE;
                    tune_next  = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            S_PARK: begin
                if (bus.abort) begin
                    state_next = S_RETURN;
                    cnt_next   = '0;
                    tune_next  = 1'b1;
                    exh_next   = 1'b0;
                end else if (cnt_reg == TRAVEL - 27'd1) begin
                    state_next = S_DWELL;
                    cnt_next   = '0;
                end
            end
            S_DWELL: begin
                if (bus.abort) begin
                    state_next = S_RETURN;
                    cnt_next   = '0;
                    tune_next  = 1'b1;
                    exh_next   = 1'b0;
                end else if (cnt_reg == DWELL - 27'd1) begin
                    cnt_next = '0;
                    if (bus.obstacle) begin
                        state_next = S_LOCKED;
                        found_next = 1'b1;
                        angle_next = lock_reg;
                        done_next  = 1'b1;
                    end else if (sum <= {1'b0, MAX_ANGLE}) begin
                        lock_next = sum[16:0];
                    end else begin
                        state_next = S_RETURN;
                        tune_next  = 1'b1;
                        exh_next   = 1'b1;
                    end
                end
            end
            S_LOCKED: begin
                cnt_next  = '0;
                lock_next = angle_reg;
                if (bus.abort) begin
                    state_next = S_RETURN;
                    tune_next  = 1'b1;
                    exh_next   = 1'b0;
                end
            end
            S_RETURN: begin
                // Only an exhausted sweep reports completion on the way home.
                if (cnt_reg == TRAVEL - 27'd1) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                    busy_next  = 1'b0;
                    lock_next  = MIN_ANGLE;
                    done_next  = exh_reg;
                    exh_next   = 1'b0;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
                tune_next  = 1'b1;
                busy_next  = 1'b0;
                lock_next  = MIN_ANGLE;
            end
        endcase
    end

    always_ff @(posedge clk3) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            lock_reg   <= MIN_ANGLE;
            angle_reg  <= '0;
            holder_reg <= 1'b1;
            tune_reg   <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            found_reg  <= 1'b0;
            exh_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            lock_reg   <= lock_next;
            angle_reg  <= angle_next;
            holder_reg <= 1'b1;
            tune_reg   <= tune_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            found_reg  <= found_next;
            exh_reg    <= exh_next;
        end
    end

    assign bus.holder      = holder_reg;
    assign bus.tune        = tune_reg;
    assign bus.lock        = lock_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.found       = found_reg;
    assign bus.found_angle = angle_reg;
endmodule

// File: tb/tb_servo_scan_ctrl.sv
// Directed bench for servo_scan_ctrl with short DWELL/TRAVEL; sweep results
// are queued when a sweep is launched and checked whenever done pulses.
module tb_servo_scan_ctrl;
    localparam int MIN_A = 23000;
    localparam int STP   = 8667;

    typedef struct packed {
        logic        f;
        logic [16:0] a;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   k;
    int   n;

    servo_scan_ctrl_if bus();

    servo_scan_ctrl #(
        .DWELL  (27'd10),
        .TRAVEL (27'd20)
    ) dut (
        .clk3  (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Every cycle boundary: any done pulse must match the next queued result.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (bus.done === 1'b1) begin
            check("done_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("done_found", 32'(bus.found), 32'(e.f));
                check("done_found_angle", 32'(bus.found_angle), 32'(e.a));
                $display("sweep concluded: found=%0d angle=%0d", bus.found, bus.found_angle);
            end
        end
    endtask

    // mode 0: no obstacle, 1: hit on last cycle of position 2,
    // 2: obstacle on all but the sampled cycle, 3: abort during position 4.
    task automatic run_sweep(input int mode, input int max_k, output int kk);
        int p;
        int c;
        kk = 1;
        while (bus.busy === 1'b1 && kk <= max_k) begin
            p = (kk <= 20) ? 0 : (kk - 21) / 10;
            c = (kk - 21) % 10;
            check("sweep_tune", 32'(bus.tune), (kk <= 140) ? 32'd0 : 32'd1);
            if (kk <= 140)
                check("sweep_lock", 32'(bus.lock), 32'(MIN_A + p * STP));
            bus.obstacle = 1'b0;
            if (kk >= 21 && kk <= 140) begin
                if (mode == 1) bus.obstacle = (p == 2 && c == 9);
                if (mode == 2) bus.obstacle = (c != 9);
            end
            if (mode == 3 && kk == 63) begin
                bus.abort = 1'b1;
                bus.start = 1'b1;
            end
            tick();
            kk++;
        end
        bus.obstacle = 1'b0;
        bus.abort    = 1'b0;
    endtask

    task automatic count_return(output int cnt);
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 100) begin
            check("return_tune", 32'(bus.tune), 32'd1);
            tick();
            cnt++;
        end
    endtask

    task automatic launch();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.obstacle = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state, held while start stays low
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_holder", 32'(bus.holder), 32'd1);
            check("rst_tune", 32'(bus.tune), 32'd1);
            check("rst_lock", 32'(bus.lock), 32'(MIN_A));
            check("rst_busy", 32'(bus.busy), 32'd0);
            check("rst_done", 32'(bus.done), 32'd0);
            check("rst_found", 32'(bus.found), 32'd0);
            check("rst_found_angle", 32'(bus.found_angle), 32'd0);
        end

        // Full sweep with no obstacle
        q.push_back('{f: 1'b0, a: 17'd0});
        launch();
        run_sweep(0, 200, k);
        check("full_busy_cycles", 32'(k - 1), 32'd160);
        check("full_idle_lock", 32'(bus.lock), 32'(MIN_A));
        check("full_found", 32'(bus.found), 32'd0);
        repeat (3) tick();

        // Hit on the 10th cycle of the 3rd position
        q.push_back('{f: 1'b1, a: 17'd40334});
        launch();
        run_sweep(1, 50, k);
        bus.start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("hit_found", 32'(bus.found), 32'd1);
            check("hit_angle", 32'(bus.found_angle), 32'd40334);
            check("hit_lock", 32'(bus.lock), 32'd40334);
            check("hit_busy", 32'(bus.busy), 32'd1);
            check("hit_tune", 32'(bus.tune), 32'd0);
            tick();
        end
        bus.start = 1'b0;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        count_return(n);
        check("hit_return_cycles", 32'(n), 32'd20);
        check("hit_found_after", 32'(bus.found), 32'd1);
        check("hit_lock_after", 32'(bus.lock), 32'(MIN_A));
        repeat (3) tick();

        // Obstacle present except on the sampled cycle: never triggers
        q.push_back('{f: 1'b0, a: 17'd0});
        launch();
        run_sweep(2, 200, k);
        check("miss_busy_cycles", 32'(k - 1), 32'd160);
        check("miss_found", 32'(bus.found), 32'd0);
        repeat (3) tick();

        // Abort in 5th position with start held through RETURN
        launch();
        run_sweep(3, 63, k);
        check("abort_tune", 32'(bus.tune), 32'd1);
        count_return(n);
        check("abort_return_cycles", 32'(n), 32'd20);
        check("abort_idle_busy", 32'(bus.busy), 32'd0);
        check("abort_idle_done", 32'(bus.done), 32'd0);
        check("abort_found", 32'(bus.found), 32'd0);
        tick();
        bus.start = 1'b0;
        check("restart_busy", 32'(bus.busy), 32'd1);
        check("restart_tune", 32'(bus.tune), 32'd0);
        check("restart_lock", 32'(bus.lock), 32'(MIN_A));
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        count_return(n);
        check("park_abort_return", 32'(n), 32'd20);
        repeat (3) tick();

        // Reset mid-DWELL on the sampled cycle with obstacle high
        launch();
        run_sweep(0, 49, k);
        bus.obstacle = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.obstacle = 1'b0;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_tune", 32'(bus.tune), 32'd1);
        check("mid_rst_holder", 32'(bus.holder), 32'd1);
        check("mid_rst_lock", 32'(bus.lock), 32'(MIN_A));
        check("mid_rst_found", 32'(bus.found), 32'd0);
        check("mid_rst_angle", 32'(bus.found_angle), 32'd0);
        repeat (5) tick();

        check("pending_results", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
